// File: rtl/abc_ascii_uint_parser.sv
// abc_ascii_uint_parser: turns an ASCII byte stream into one binary integer per space/LF-delimited token.
// Optional signed tokens ('-' prefix, two's complement output) when ABC_PARSER_SIGNED_EN is defined.
module abc_ascii_uint_parser #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SINK_VALID,
  input  logic [7:0]        SINK_DATA,
  output logic              SOURCE_VALID,
  output logic [DATA_W-1:0] SOURCE_DATA,
  output logic              SOURCE_EOL,
  output logic              ERROR
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W+3:0] mul10;
  logic              mul_ovf;
  logic              is_digit, is_lf, is_sep, is_cr;
  logic [3:0]        dig;
  logic              emit, emit_err;
  logic [DATA_W-1:0] emit_data;
  logic              valid_q, eol_q, err_q;
  logic [DATA_W-1:0] data_q;
  assign is_digit = (SINK_DATA >= 8'h30) && (SINK_DATA <= 8'h39);
  assign is_lf    = SINK_DATA == 8'h0A;
  assign is_sep   = is_lf || (SINK_DATA == 8'h20);
  assign is_cr    = SINK_DATA == 8'h0D;
  assign dig      = SINK_DATA[3:0];
  // acc*10 + d with 4 guard bits; any set guard bit means the value no longer fits
  assign mul10    = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{DATA_W{1'b0}}, dig};
  assign mul_ovf  = |mul10[DATA_W+3:DATA_W];
  assign emit     = SINK_VALID && is_sep && (state_q != S_IDLE);
`ifdef ABC_PARSER_SIGNED_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic neg_q, neg_d, seen_q, seen_d, is_minus, too_big, bad;
  assign is_minus  = SINK_DATA == 8'h2D;
  assign too_big   = ovf_q || (neg_q ? (acc_q > MIN_NEG) : (acc_q > MAX_POS));
  assign bad       = (state_q != S_NUM) || !seen_q;
  assign emit_err  = bad || too_big;
  assign emit_data = bad ? '0 : too_big ? (neg_q ? MIN_NEG : MAX_POS) : neg_q ? -acc_q : acc_q;
`else
  assign emit_err  = (state_q != S_NUM) || ovf_q;
  assign emit_data = (state_q != S_NUM) ? '0 : ovf_q ? '1 : acc_q;
`endif
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
`ifdef ABC_PARSER_SIGNED_EN
    neg_d   = neg_q;
    seen_d  = seen_q;
`endif
    if (SINK_VALID && !is_cr) begin
      if (state_q == S_IDLE) begin
        if (is_digit) begin
          state_d = S_NUM;
          acc_d   = {{(DATA_W-4){1'b0}}, dig};
          ovf_d   = 1'b0;
`ifdef ABC_PARSER_SIGNED_EN
          neg_d   = 1'b0;
          seen_d  = 1'b1;
        end else if (is_minus) begin
          state_d = S_NUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          neg_d   = 1'b1;
          seen_d  = 1'b0;
`endif
        end else if (!is_sep) begin
          state_d = S_DROP;
        end
      end else if (state_q == S_NUM) begin
        if (is_digit) begin
          ovf_d   = ovf_q || mul_ovf;
          acc_d   = (ovf_q || mul_ovf) ? '1 : mul10[DATA_W-1:0];
`ifdef ABC_PARSER_SIGNED_EN
          seen_d  = 1'b1;
`endif
        end else begin
          state_d = is_sep ? S_IDLE : S_DROP;
        end
      end else if (is_sep) begin
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
`ifdef ABC_PARSER_SIGNED_EN
      neg_q   <= 1'b0;
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= emit;
      eol_q   <= emit && is_lf;
      err_q   <= emit && emit_err;
      if (emit) data_q <= emit_data;
`ifdef ABC_PARSER_SIGNED_EN
      neg_q   <= neg_d;
      seen_q  <= seen_d;
`endif
    end
  end
  assign SOURCE_VALID = valid_q;
  assign SOURCE_DATA  = data_q;
  assign SOURCE_EOL   = eol_q;
  assign ERROR        = err_q;
endmodule
